// File: rtl/raster_cmd_pkg.sv
// Shared definitions for the rasterizer command stream (encoder and decoder).
package raster_cmd_pkg;

  // Wire command codes carried in word bits [6:5]
  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_PIXEL = 2'b01;
  localparam logic [1:0] CMD_LINE  = 2'b10;
  localparam logic [1:0] CMD_RECT  = 2'b11;

  // CLEAR reuses the PIXEL code with a parameter PIXEL can never produce
  localparam logic [4:0] CLEAR_PARAM = 5'h1F;
  localparam int         EN_BIT      = 7;

  // Host-side request op codes
  typedef enum logic [1:0] {
    OP_PIXEL = 2'd0,
    OP_LINE  = 2'd1,
    OP_RECT  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  // Number of words each request expands into
  localparam int WORDS_PIXEL = 2;
  localparam int WORDS_LINE  = 4;
  localparam int WORDS_RECT  = 4;
  localparam int WORDS_CLEAR = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Index of the final word of a command
  function automatic logic [1:0] last_index(input op_e op);
    case (op)
      OP_PIXEL: last_index = 2'(WORDS_PIXEL - 1);
      OP_LINE:  last_index = 2'(WORDS_LINE - 1);
      OP_RECT:  last_index = 2'(WORDS_RECT - 1);
      default:  last_index = 2'(WORDS_CLEAR - 1);
    endcase
  endfunction

endpackage

// File: rtl/raster_cmd_encoder.sv
// Serializes one draw request into decoder command words, one per clock,
// followed by GAP idle (en=0) cycles. GAP must lie in 1..15.
module raster_cmd_encoder
  import raster_cmd_pkg::*;
#(
  parameter int unsigned GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [2:0] req_a,
  input  logic [2:0] req_b,
  input  logic [2:0] req_c,
  input  logic [2:0] req_d,
  input  logic       hold,
  output logic [7:0] stream_out,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  gap_q, gap_d;
  op_e         op_q, op_d;
  logic [2:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [7:0]  stream_q, word_d;
  logic        busy_q, done_q, done_d;
  logic [1:0]  cmd_sel;
  logic [4:0]  param_sel;
  logic        accept;

  // Ready only in IDLE; hold and reset both block acceptance
  assign req_ready = (state_q == ST_IDLE) && !hold && !rst;
  assign accept    = req_valid && req_ready;

  // Next-state: capture on acceptance, walk word index, then count the gap
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EMIT;
          idx_d   = 2'd0;
          op_d    = op_e'(req_op);
          a_d     = req_a;
          b_d     = req_b;
          c_d     = req_c;
          d_d     = req_d;
        end
      end
      ST_EMIT: begin
        if (idx_q == last_index(op_q)) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_GAP: begin
        if (gap_q <= 4'd1) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Word mux on the upcoming (op, index) so the word lands in the output register
  always_comb begin
    cmd_sel   = CMD_NOP;
    param_sel = '0;
    case (idx_d)
      2'd0: begin
        param_sel = {2'b00, a_d};
        case (op_d)
          OP_PIXEL: cmd_sel = CMD_PIXEL;
          OP_LINE:  cmd_sel = CMD_LINE;
          OP_RECT:  cmd_sel = CMD_RECT;
          default: begin
            cmd_sel   = CMD_PIXEL;
            param_sel = CLEAR_PARAM;
          end
        endcase
      end
      2'd1:    param_sel = {2'b00, b_d};
      2'd2:    param_sel = {2'b00, c_d};
      default: param_sel = {2'b00, d_d};
    endcase
    word_d = '0;
    if (state_d == ST_EMIT) begin
      word_d[EN_BIT] = 1'b1;
      word_d[6:5]    = cmd_sel;
      word_d[4:0]    = param_sel;
    end
    done_d = (state_d == ST_EMIT) && (idx_d == last_index(op_d));
  end

  // State and registered outputs; reset truncates any command in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      op_q     <= OP_PIXEL;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      stream_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      stream_q <= word_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= done_d;
    end
  end

  assign stream_out = stream_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
